// File: rtl/multicycle_ctrl_seq_pkg.sv
// Shared encodings for the DaVinci multi-cycle control sequencer.
// States, opcodes, ALU codes and control-field enums.
package multicycle_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_PUSH  = 6'h1C;
  localparam logic [5:0] OP_POP   = 6'h1D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0, PC_BR = 2'd1,
    PC_JUMP = 2'd2, PC_REG = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0, WB_MEM = 2'd1,
    WB_PC1 = 2'd2, WB_LUI = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    RD_RT = 2'd0, RD_RD = 2'd1,
    RD_R31 = 2'd2, RD_R0 = 2'd3
  } reg_dst_e;

  typedef enum logic [1:0] {
    AS_PC = 2'd0, AS_ALU = 2'd1, AS_SP = 2'd2
  } addr_sel_e;

  typedef enum logic [2:0] {
    MC_NONE, MC_LW, MC_SW, MC_PUSH, MC_POP
  } mem_cls_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_JMP, BR_JR
  } br_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     alu_src_imm;
    logic     imm_zext;
    reg_dst_e reg_dst;
    wb_sel_e  wb_sel;
    mem_cls_e mem_cls;
    br_e      br;
    logic     reg_write;
    logic     illegal;
  } dec_t;

  function automatic logic mem_access(mem_cls_e c);
    return c != MC_NONE;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_seq_if.sv
// Instruction/data memory port between the sequencer and memory.
// READ/WRITE requests complete when MEM_READY is high.
interface multicycle_ctrl_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] INSTRUCTION;
  logic                  MEM_READY;
  logic                  READ;
  logic                  WRITE;
  logic [1:0]            MEM_ADDR_SEL;

  modport master (
    output READ, WRITE, MEM_ADDR_SEL,
    input  INSTRUCTION, MEM_READY
  );

  modport slave (
    input  READ, WRITE, MEM_ADDR_SEL,
    output INSTRUCTION, MEM_READY
  );
endinterface

// File: rtl/multicycle_ctrl_seq_decode.sv
// Combinational instruction decoder: opcode/funct to named
// control fields, memory class, branch type and illegal flag.
module ctrl_decode
  import multicycle_ctrl_seq_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.reg_dst = RD_RT;
    dec.wb_sel  = WB_ALU;
    dec.mem_cls = MC_NONE;
    dec.br      = BR_NONE;
    unique case (1'b1)
      op == OP_RTYPE: begin
        dec.reg_dst   = RD_RD;
        dec.reg_write = 1'b1;
        unique case (1'b1)
          fn == FN_ADD: dec.alu_op = ALU_ADD;
          fn == FN_SUB: dec.alu_op = ALU_SUB;
          fn == FN_AND: dec.alu_op = ALU_AND;
          fn == FN_OR:  dec.alu_op = ALU_OR;
          fn == FN_SLT: dec.alu_op = ALU_SLT;
          fn == FN_JR: begin
            dec.br        = BR_JR;
            dec.reg_write = 1'b0;
          end
          default: begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      op == OP_ADDI: begin
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      op == OP_ANDI: begin
        dec.alu_op      = ALU_AND;
        dec.alu_src_imm = 1'b1;
        dec.imm_zext    = 1'b1;
        dec.reg_write   = 1'b1;
      end
      op == OP_ORI: begin
        dec.alu_op      = ALU_OR;
        dec.alu_src_imm = 1'b1;
        dec.imm_zext    = 1'b1;
        dec.reg_write   = 1'b1;
      end
      op == OP_LUI: begin
        dec.alu_src_imm = 1'b1;
        dec.wb_sel      = WB_LUI;
        dec.reg_write   = 1'b1;
      end
      op == OP_LW: begin
        dec.alu_src_imm = 1'b1;
        dec.mem_cls     = MC_LW;
        dec.wb_sel      = WB_MEM;
        dec.reg_write   = 1'b1;
      end
      op == OP_SW: begin
        dec.alu_src_imm = 1'b1;
        dec.mem_cls     = MC_SW;
      end
      op == OP_PUSH: dec.mem_cls = MC_PUSH;
      op == OP_POP: begin
        dec.mem_cls   = MC_POP;
        dec.reg_dst   = RD_R0;
        dec.wb_sel    = WB_MEM;
        dec.reg_write = 1'b1;
      end
      op == OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.br     = BR_BEQ;
      end
      op == OP_BNE: begin
        dec.alu_op = ALU_SUB;
        dec.br     = BR_BNE;
      end
      op == OP_JMP: dec.br = BR_JMP;
      op == OP_JAL: begin
        dec.br        = BR_JMP;
        dec.reg_dst   = RD_R31;
        dec.wb_sel    = WB_PC1;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB control sequencer with
// memory wait states, timeout, MEM bypass and opcode trapping.
module multicycle_ctrl_seq
  import multicycle_ctrl_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int SKIP_MEM    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  multicycle_ctrl_seq_if.master mem,
  input  logic                  ZERO,
  output logic [2:0]            STATE,
  output logic [DATA_WIDTH-1:0] IR,
  output logic [3:0]            ALU_OP,
  output logic                  ALU_SRC_IMM,
  output logic                  IMM_ZEXT,
  output logic                  REG_WRITE,
  output logic [1:0]            REG_DST,
  output logic [1:0]            WB_SEL,
  output logic                  PC_LOAD,
  output logic [1:0]            PC_SEL,
  output logic                  SP_INC,
  output logic                  SP_DEC,
  output logic                  TRAP,
  output logic                  ERROR
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam bit ALL_MEM = (SKIP_MEM == 0);

  state_e                state, state_nx;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [7:0]            cnt;
  logic                  fetch_en;
  logic                  req;
  dec_t                  dec;

  ctrl_decode u_dec (
    .op  (ir_q[31:26]),
    .fn  (ir_q[5:0]),
    .dec (dec)
  );

  assign req   = mem.READ | mem.WRITE;
  assign STATE = state;
  assign IR    = ir_q;
  assign ERROR = (state == S_ERROR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_FETCH;
    else      state <= state_nx;
  end

  // fetch_en keeps READ low while reset is held and for one cycle after
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ir_q     <= '0;
      cnt      <= '0;
      fetch_en <= 1'b0;
    end else begin
      fetch_en <= 1'b1;
      if (state == S_FETCH && fetch_en && mem.MEM_READY)
        ir_q <= mem.INSTRUCTION;
      if (state_nx != state)
        cnt <= '0;
      else if (req && !mem.MEM_READY)
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: begin
        if (fetch_en && mem.MEM_READY) state_nx = S_DECODE;
        else if (fetch_en && cnt == TO_LAST) state_nx = S_ERROR;
      end
      S_DECODE:
        state_nx = dec.illegal ? S_FETCH : S_EXE;
      S_EXE:
        state_nx = (mem_access(dec.mem_cls) || ALL_MEM) ? S_MEM : S_WB;
      S_MEM: begin
        if (!req || mem.MEM_READY) state_nx = S_WB;
        else if (cnt == TO_LAST) state_nx = S_ERROR;
      end
      S_WB:    state_nx = S_FETCH;
      S_ERROR: state_nx = S_ERROR;
      default: state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    mem.READ         = 1'b0;
    mem.WRITE        = 1'b0;
    mem.MEM_ADDR_SEL = AS_PC;
    ALU_OP           = ALU_ADD;
    ALU_SRC_IMM      = 1'b0;
    IMM_ZEXT         = 1'b0;
    REG_WRITE        = 1'b0;
    REG_DST          = RD_RT;
    WB_SEL           = WB_ALU;
    PC_LOAD          = 1'b0;
    PC_SEL           = PC_INC;
    SP_INC           = 1'b0;
    SP_DEC           = 1'b0;
    TRAP             = 1'b0;
    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      ALU_OP      = dec.alu_op;
      ALU_SRC_IMM = dec.alu_src_imm;
      IMM_ZEXT    = dec.imm_zext;
    end
    unique case (state)
      S_FETCH:  mem.READ = fetch_en;
      S_DECODE: TRAP = dec.illegal;
      S_EXE:    SP_INC = (dec.mem_cls == MC_POP);
      S_MEM: begin
        mem.READ  = (dec.mem_cls == MC_LW) || (dec.mem_cls == MC_POP);
        mem.WRITE = (dec.mem_cls == MC_SW) || (dec.mem_cls == MC_PUSH);
        if (dec.mem_cls == MC_LW || dec.mem_cls == MC_SW)
          mem.MEM_ADDR_SEL = AS_ALU;
        else if (dec.mem_cls == MC_PUSH || dec.mem_cls == MC_POP)
          mem.MEM_ADDR_SEL = AS_SP;
      end
      S_WB: begin
        PC_LOAD   = 1'b1;
        REG_WRITE = dec.reg_write;
        REG_DST   = dec.reg_dst;
        WB_SEL    = dec.wb_sel;
        SP_DEC    = (dec.mem_cls == MC_PUSH);
        unique case (dec.br)
          BR_BEQ:  PC_SEL = ZERO ? PC_BR : PC_INC;
          BR_BNE:  PC_SEL = ZERO ? PC_INC : PC_BR;
          BR_JMP:  PC_SEL = PC_JUMP;
          BR_JR:   PC_SEL = PC_REG;
          default: PC_SEL = PC_INC;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl_seq.md
Name: multicycle_ctrl_seq

Overview:
Parametrised multi-cycle control sequencer for the DaVinci datapath. It adds the following to the fixed FETCH/DECODE/EXE/MEM/WB control unit:
- a memory ready handshake with wait states and timeout;
- an optional MEM-state bypass for non-memory instructions;
- illegal-opcode trapping;
- decoded, named control fields instead of one packed control word.

It sits between the instruction/data memory port and the datapath (register file, ALU, PC).

Parameters:
DATA_WIDTH, 32, instruction and data word width; opcode = IR[31:26], funct = IR[5:0].
MEM_TIMEOUT, 15, maximum cycles to wait for MEM_READY before entering ERROR (1..255).
SKIP_MEM, 1, if 1, instructions other than lw/sw/push/pop go EXE->WB directly; if 0, every instruction visits MEM.

Ports:
CLK  in  1  clock, all state updates on rising edge.
RST  in  1  asynchronous active-low reset.
INSTRUCTION  in  DATA_WIDTH  memory read data during FETCH.
ZERO  in  1  ALU zero flag, sampled in WB.
MEM_READY  in  1  memory completes the current READ/WRITE this cycle.
READ  out  1  memory read request.
WRITE  out  1  memory write request.
STATE  out  3  current state; encodings from the shared package.
IR  out  DATA_WIDTH  latched instruction register.
ALU_OP  out  4  ALU operation code from the package.
ALU_SRC_IMM  out  1  ALU operand B is the immediate.
IMM_ZEXT  out  1  zero-extend immediate (andi/ori); otherwise sign-extend.
MEM_ADDR_SEL  out  2  memory address source: 0 PC, 1 ALU result, 2 SP.
REG_WRITE  out  1  register-file write enable (WB only).
REG_DST  out  2  destination register: 0 rt, 1 rd, 2 r31, 3 r0 (pop).
WB_SEL  out  2  write-back data: 0 ALU, 1 memory data, 2 PC+1, 3 {imm,16'b0}.
PC_LOAD  out  1  PC update strobe (WB only).
PC_SEL  out  2  next PC: 0 PC+1, 1 PC+1+branch offset, 2 jump address, 3 R[rs].
SP_INC  out  1  increment $sp.
SP_DEC  out  1  decrement $sp.
TRAP  out  1  one-cycle pulse when an illegal opcode or funct is decoded.
ERROR  out  1  sticky memory timeout flag.

Behaviour:
- Reset (RST=0, asynchronous):
  - STATE=FETCH, IR=0, timeout counter=0.
  - ERROR=0, TRAP=0.
  - All other control outputs 0.
  - Reset during a wait state abandons the access; READ/WRITE drop immediately.
- FETCH:
  - Outputs: READ=1, MEM_ADDR_SEL=0.
  - Hold in FETCH while MEM_READY=0.
  - On MEM_READY=1: IR<=INSTRUCTION, go to DECODE.
- DECODE:
  - One cycle. Decode IR combinationally; go to EXE.
  - Unknown opcode or funct: TRAP pulse for this cycle; next state FETCH with PC_LOAD=0. The instruction is skipped and the PC does not advance; software or the bench handles it.
- EXE:
  - One cycle. ALU_OP, ALU_SRC_IMM and IMM_ZEXT are valid and are held through MEM and WB.
  - Next state is MEM for lw/sw/push/pop, or when SKIP_MEM=0; otherwise WB.
- MEM:
  - lw/pop: READ=1. sw/push: WRITE=1. Other instructions: idle for one cycle.
  - MEM_ADDR_SEL: 1 for lw/sw, 2 for push/pop.
  - pop: SP_INC=1 in the cycle that enters MEM (the last EXE cycle), so the address is the incremented SP.
  - Hold while MEM_READY=0, then go to WB.
- WB:
  - One cycle. PC_LOAD=1. REG_WRITE=1 for ALU ops, lw, pop, jal, lui.
  - push: SP_DEC=1. Then go to FETCH.
  - PC_SEL:
    - beq: 1 if ZERO=1, else 0.
    - bne: 1 if ZERO=0, else 0.
    - jmp/jal: 2.
    - jr: 3.
    - all others: 0.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle READ or WRITE is high and MEM_READY=0.
  - When the counter reaches MEM_TIMEOUT: go to ERROR. ERROR=1, READ=WRITE=0, all strobes 0.
  - ERROR is left only by reset.
  - MEM_READY arriving in the same cycle the counter reaches the limit wins: the access completes, no error.
- Output timing and idle levels:
  - Outputs are registered or derived from the registered STATE and IR only; no combinational path from MEM_READY to READ/WRITE.
  - Outside their own states, REG_WRITE, PC_LOAD, SP_INC, SP_DEC and TRAP are 0.
- Throughput with zero wait states: 4 cycles for non-memory instructions (SKIP_MEM=1), 5 otherwise.

Decomposition:
- Shared package/include:
  - state encodings FETCH, DECODE, EXE, MEM, WB, ERROR;
  - opcode and funct constants;
  - ALU_OP codes;
  - PC_SEL, WB_SEL, REG_DST and MEM_ADDR_SEL enumerations.
- One sub-module, ctrl_decode:
  - purely combinational, IR -> {ALU_OP, ALU_SRC_IMM, IMM_ZEXT, REG_DST, WB_SEL, mem class, branch/jump type, illegal}.
- The top level holds the FSM, timeout counter and IR.

Test Plan:
1. add r3,r1,r2 (IR=0x00221820), MEM_READY always 1, SKIP_MEM=1 -> states F,D,E,W. In WB: REG_WRITE=1, REG_DST=1, WB_SEL=0, PC_SEL=0. 4 cycles total.
2. lw with MEM_READY delayed 3 cycles in MEM -> READ=1 held 4 cycles, MEM_ADDR_SEL=1. WB: REG_WRITE=1, WB_SEL=1. ERROR stays 0.
3. beq executed twice, ZERO=1 then ZERO=0 -> PC_SEL=1, then PC_SEL=0. PC_LOAD=1 in each WB; REG_WRITE=0.
4. Opcode 0x3F -> TRAP=1 for exactly one cycle in DECODE, next state FETCH. No PC_LOAD or REG_WRITE asserted.
5. MEM_READY held 0 in FETCH with MEM_TIMEOUT=15 -> ERROR=1 after 15 cycles, READ=0. Stays in ERROR until RST=0, which returns to FETCH.
6. RST asserted mid-MEM of a sw with WRITE=1 -> WRITE=0 immediately (asynchronous), STATE=FETCH, IR=0. Normal fetch after release.
